// File: rtl/knn_topk_sorter_if.sv
// knn_topk_sorter_if: candidate/result handshake bundle for the top-K sorter.
//   Candidate side : in_valid, in_ready, in_dist, in_carry, in_label, in_last
//   Result side    : out_valid, out_ready, out_dist, out_label, out_count
//   master modport : the producer/consumer around the sorter (e.g. testbench)
//   slave modport  : the sorter itself
interface knn_topk_sorter_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int LABEL_WIDTH = 4,
    parameter int K           = 4
);
    localparam int CW = $clog2(K + 1);

    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_WIDTH-1:0]    in_dist;
    logic                     in_carry;
    logic [LABEL_WIDTH-1:0]   in_label;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [K*DATA_WIDTH-1:0]  out_dist;
    logic [K*LABEL_WIDTH-1:0] out_label;
    logic [CW-1:0]            out_count;

    modport master (
        output in_valid, in_dist, in_carry, in_label, in_last, out_ready,
        input  in_ready, out_valid, out_dist, out_label, out_count
    );

    modport slave (
        input  in_valid, in_dist, in_carry, in_label, in_last, out_ready,
        output in_ready, out_valid, out_dist, out_label, out_count
    );
endinterface

// File: rtl/knn_topk_sorter.sv
// knn_topk_sorter: streaming top-K selector. Accepts one distance/label per
// cycle while collecting, keeps the K smallest in ascending order (ties in
// arrival order), and after the last candidate of a query holds the sorted
// list on the result handshake until it is taken.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : knn_topk_sorter_if.slave (candidate in, sorted result out)
module knn_topk_sorter #(
    parameter int DATA_WIDTH  = 8,
    parameter int LABEL_WIDTH = 4,
    parameter int K           = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    knn_topk_sorter_if.slave     bus
);
    localparam int CW = $clog2(K + 1);

    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_e;

    state_e                             state_q, state_d;
    logic [K-1:0][DATA_WIDTH-1:0]       dist_q, dist_d;
    logic [K-1:0][LABEL_WIDTH-1:0]      lbl_q, lbl_d;
    logic [CW-1:0]                      cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0]              eff_dist;
    logic [K-1:0]                       le;
    logic                               prev_le;
    logic [DATA_WIDTH-1:0]              prev_dist;
    logic [LABEL_WIDTH-1:0]             prev_lbl;

    // Overflowed accumulations compare as the largest possible distance.
    assign eff_dist = bus.in_carry ? {DATA_WIDTH{1'b1}} : bus.in_dist;

    always_comb begin
        state_d   = state_q;
        dist_d    = dist_q;
        lbl_d     = lbl_q;
        cnt_d     = cnt_q;
        le        = '0;
        prev_le   = 1'b1;
        prev_dist = '1;
        prev_lbl  = '0;

        // le[i]: slot i is filled and stays below the new entry. Because the
        // list is sorted and filled slots form a prefix, le is a prefix mask;
        // the first clear bit is the insertion point, later slots shift up.
        for (int i = 0; i < K; i++) begin
            le[i] = (CW'(i) < cnt_q) && (dist_q[i] <= eff_dist);
        end

        case (state_q)
            COLLECT: begin
                if (bus.in_valid) begin
                    for (int i = 0; i < K; i++) begin
                        if (!le[i]) begin
                            if (prev_le) begin
                                dist_d[i] = eff_dist;
                                lbl_d[i]  = bus.in_label;
                            end else begin
                                dist_d[i] = prev_dist;
                                lbl_d[i]  = prev_lbl;
                            end
                        end
                        prev_le   = le[i];
                        prev_dist = dist_q[i];
                        prev_lbl  = lbl_q[i];
                    end
                    if (cnt_q != CW'(K)) cnt_d = cnt_q + CW'(1);
                    if (bus.in_last) state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    dist_d  = '1;
                    lbl_d   = '0;
                    cnt_d   = '0;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            dist_q  <= '1;
            lbl_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dist_q  <= dist_d;
            lbl_q   <= lbl_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake flags decode from state only.
    assign bus.in_ready  = (state_q == COLLECT);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_dist  = dist_q;
    assign bus.out_label = lbl_q;
    assign bus.out_count = cnt_q;
endmodule

// File: tb/tb_knn_topk_sorter.sv
// tb_knn_topk_sorter: directed checks of the top-K sorter (K=4, 8-bit
// distances, 4-bit labels) with hand-computed expected lists.
module tb_knn_topk_sorter;
    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    knn_topk_sorter_if #(.DATA_WIDTH(8), .LABEL_WIDTH(4), .K(4)) bus ();

    knn_topk_sorter #(.DATA_WIDTH(8), .LABEL_WIDTH(4), .K(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a candidate and let one edge take it (in_ready is 1 in COLLECT).
    task automatic send(input logic [7:0] d, input logic c, input logic [3:0] l, input logic last);
        bus.in_valid = 1'b1;
        bus.in_dist  = d;
        bus.in_carry = c;
        bus.in_label = l;
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_carry = 1'b0;
    endtask

    task automatic chk_res(input string tag, input logic [31:0] d, input logic [15:0] l, input logic [2:0] c);
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, "_dist"},  bus.out_dist, d);
        chk({tag, "_label"}, {16'd0, bus.out_label}, {16'd0, l});
        chk({tag, "_count"}, {29'd0, bus.out_count}, {29'd0, c});
    endtask

    task automatic take(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_rel_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_rel_ready"}, {31'd0, bus.in_ready}, 32'd1);
        chk({tag, "_rel_count"}, {29'd0, bus.out_count}, 32'd0);
        chk({tag, "_rel_dist"},  bus.out_dist, 32'hFFFFFFFF);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_dist   = '0;
        bus.in_carry  = 1'b0;
        bus.in_label  = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();

        // reset state
        chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_count", {29'd0, bus.out_count}, 32'd0);
        chk("rst_dist",  bus.out_dist, 32'hFFFFFFFF);
        chk("rst_label", {16'd0, bus.out_label}, 32'd0);

        // five back-to-back candidates, one displaced
        send(8'd50, 1'b0, 4'd1, 1'b0);
        send(8'd20, 1'b0, 4'd2, 1'b0);
        send(8'd80, 1'b0, 4'd3, 1'b0);
        send(8'd10, 1'b0, 4'd4, 1'b0);
        chk("t1_mid_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t1_mid_dist",  bus.out_dist, 32'h50_32_14_0A);
        send(8'd30, 1'b0, 4'd5, 1'b1);
        chk_res("t1", 32'h32_1E_14_0A, 16'h1524, 3'd4);
        take("t1");

        // ties keep arrival order, partial fill
        send(8'd7, 1'b0, 4'd1, 1'b0);
        send(8'd7, 1'b0, 4'd2, 1'b0);
        send(8'd3, 1'b0, 4'd3, 1'b1);
        chk_res("t2", 32'hFF_07_07_03, 16'h0213, 3'd3);
        take("t2");

        // full list, candidate equal to slot K-1 is rejected
        send(8'd1, 1'b0, 4'd1, 1'b0);
        send(8'd2, 1'b0, 4'd2, 1'b0);
        send(8'd3, 1'b0, 4'd3, 1'b0);
        send(8'd4, 1'b0, 4'd4, 1'b0);
        send(8'd4, 1'b0, 4'd5, 1'b1);
        chk_res("t3", 32'h04_03_02_01, 16'h4321, 3'd4);
        take("t3");

        // carry saturates; saturated entry still fills an empty slot
        send(8'h05, 1'b1, 4'd9, 1'b0);
        send(8'hFE, 1'b0, 4'd2, 1'b1);
        chk_res("t4", 32'hFF_FF_FF_FE, 16'h0092, 3'd2);

        // HOLD ignores in_valid and stays stable without out_ready
        bus.in_valid = 1'b1;
        bus.in_dist  = 8'd1;
        bus.in_label = 4'd7;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_ready", {31'd0, bus.in_ready}, 32'd0);
            chk_res("hold", 32'hFF_FF_FF_FE, 16'h0092, 3'd2);
        end
        bus.in_valid = 1'b0;
        take("t4");

        // reset mid-collect discards partial content
        send(8'd40, 1'b0, 4'd1, 1'b0);
        send(8'd60, 1'b0, 4'd2, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_count", {29'd0, bus.out_count}, 32'd0);
        chk("mrst_dist",  bus.out_dist, 32'hFFFFFFFF);
        send(8'd9, 1'b0, 4'd6, 1'b1);
        chk_res("t5", 32'hFF_FF_FF_09, 16'h0006, 3'd1);

        // reset while holding a result
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("hrst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("hrst_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("hrst_label", {16'd0, bus.out_label}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/knn_topk_sorter.md
# knn_topk_sorter

Streaming top-K selector for the KNN process unit. Consumes one accumulated distance per cycle, with its carry and class label, from the distance accumulator stage. Keeps the K smallest distances in ascending order and, at end of query, presents them with their labels to the voting stage over a valid/ready handshake. Accumulator overflow (carry set) is treated as a saturated, maximal distance.

## Interface
Parameters:
- DATA_WIDTH, 8, width of one distance; matches the accumulator result width
- LABEL_WIDTH, 4, width of one class label
- K, 4, number of nearest neighbours kept (K >= 1)

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  candidate present
- in_ready  out  1  sorter can accept a candidate
- in_dist  in  DATA_WIDTH  accumulated distance
- in_carry  in  1  accumulator overflow for this distance
- in_label  in  LABEL_WIDTH  class label of the training sample
- in_last  in  1  final candidate of the current query
- out_valid  out  1  sorted result available
- out_ready  in  1  downstream accepts the result
- out_dist  out  K*DATA_WIDTH  sorted distances; slot 0 (LSBs) is the smallest
- out_label  out  K*LABEL_WIDTH  labels aligned with out_dist slots
- out_count  out  $clog2(K+1)  number of filled slots, equal to min(candidates, K)

## Operation
- Two states: COLLECT and HOLD. Reset enters COLLECT with all slots empty.
- COLLECT: in_ready=1 and out_valid=0. An input handshake (in_valid & in_ready) inserts the candidate in the same cycle.
- Effective distance: {DATA_WIDTH{1'b1}} if in_carry=1, else in_dist.
- Insertion is a parallel compare-shift. The new entry goes after every filled slot whose distance is less than or equal to it, so ties keep arrival order. Later slots shift up by one. The entry in slot K-1 is dropped.
- If the list is full and the effective distance is >= slot K-1, the list is unchanged.
- Empty slots hold distance all-ones and label 0 and count as larger than any filled slot. A saturated candidate still fills an empty slot, placed after filled all-ones entries.
- out_count increments on each insertion into a non-full list and saturates at K.
- A handshake with in_last=1 inserts the candidate, then moves to HOLD.
- HOLD: in_ready=0, out_valid=1. out_dist, out_label and out_count are stable and in_valid is ignored.
- An output handshake (out_valid & out_ready) clears all slots and out_count and returns to COLLECT.
- A query that receives no candidates produces no output; in_last always comes with a valid candidate.

## Timing
- Reset values: out_valid=0, in_ready=1, out_count=0, every out_dist slot all-ones, every out_label slot 0.
- Insert latency: the slot contents reflect a candidate on the cycle after its handshake. Back-to-back candidates are accepted every cycle.
- Result latency: out_valid rises the cycle after the in_last handshake, with the list already including the last candidate.
- Output handshake: state, out_valid=0 and the cleared list take effect the next cycle. in_ready=1 from that cycle, so a new candidate is accepted one cycle after the result is taken. There is no same-cycle bypass.
- rst_n=0 in either state discards all content on the next edge, reaching the reset values regardless of in_valid or out_ready.
- Outputs are registered. in_ready and out_valid are decoded from state only, with no combinational path from in_valid or out_ready.

## Test plan
All scenarios use K=4, DATA_WIDTH=8, LABEL_WIDTH=4.
- Reset, then idle 3 cycles -> in_ready=1, out_valid=0, out_count=0, out_dist=32'hFFFFFFFF, out_label=16'h0000.
- Stream dist/label 50/1, 20/2, 80/3, 10/4, 30/5, with last on the fifth, back-to-back -> out_valid the cycle after the fifth handshake; slots 0..3 distances 10,20,30,50, labels 4,2,5,1; out_count=4.
- Stream 7/1, 7/2, 3/3 (last) -> distances 3,7,7,FF; labels 3,1,2,0; out_count=3.
- Stream dist 0x05 with in_carry=1 label 9, then 0xFE label 2 (last) -> distances FE,FF,FF,FF; labels 2,9,0,0; out_count=2.
- Hold out_ready=0 for 5 cycles in HOLD while driving in_valid=1 -> outputs unchanged and in_ready=0 throughout. Then out_ready=1 for 1 cycle -> next cycle out_valid=0, out_count=0, in_ready=1.
- Insert 2 candidates, assert rst_n=0 for 1 cycle, then stream 9/6 (last) -> distances 9,FF,FF,FF; labels 6,0,0,0; out_count=1.
